// File: rtl/camera_pkg.sv
// camera_pkg: constants shared by the camera mode controller.
//   MODE_W        : width of a mode index.
//   cam_state_e   : controller FSM state encoding.
//   mode_width()  : active width of a mode index from the resolution table.
//   mode_height() : active height of a mode index from the resolution table.
package camera_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [1:0] {
    ST_RST_ASSERT = 2'd0,
    ST_SETTLE     = 2'd1,
    ST_INIT       = 2'd2,
    ST_RUN        = 2'd3
  } cam_state_e;

  function automatic logic [15:0] mode_width(input logic [MODE_W-1:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'd640;
      3'd1:    w = 16'd800;
      3'd2:    w = 16'd1024;
      3'd3:    w = 16'd1280;
      3'd4:    w = 16'd320;
      3'd5:    w = 16'd1280;
      3'd6:    w = 16'd1600;
      3'd7:    w = 16'd1920;
      default: w = 16'd640;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] mode_height(input logic [MODE_W-1:0] idx);
    logic [15:0] h;
    case (idx)
      3'd0:    h = 16'd480;
      3'd1:    h = 16'd600;
      3'd2:    h = 16'd768;
      3'd3:    h = 16'd720;
      3'd4:    h = 16'd240;
      3'd5:    h = 16'd960;
      3'd6:    h = 16'd1200;
      3'd7:    h = 16'd1080;
      default: h = 16'd480;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/cam_mode_req.sv
// cam_mode_req: resolves user mode requests into a single reconfiguration strobe.
//   clk, rst          : clock, synchronous active-high reset.
//   mode_up/mode_down : step requests (both together cancel).
//   sel_valid/sel_mode: direct select, wins over steps; out-of-range targets ignored.
//   cfg_mode          : mode currently configured or running.
//   in_run            : controller is in RUN and can act on a request now.
//   target/strobe     : reconfigure to target (only asserted while in_run).
// Outside RUN requests collect in a one-deep pending slot (latest wins).
module cam_mode_req
  import camera_pkg::*;
#(
  parameter int MODE_NUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_up,
  input  logic              mode_down,
  input  logic              sel_valid,
  input  logic [MODE_W-1:0] sel_mode,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic              in_run,
  output logic [MODE_W-1:0] target,
  output logic              strobe
);

  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(MODE_NUM - 1);
  localparam logic [MODE_W:0]   MODE_LIM  = (MODE_W + 1)'(MODE_NUM);

  logic              pend_valid_r;
  logic [MODE_W-1:0] pend_mode_r;
  logic              pend_valid_s;
  logic [MODE_W-1:0] pend_mode_s;
  logic [MODE_W-1:0] base_s;
  logic              req_valid_s;
  logic [MODE_W-1:0] req_mode_s;
  logic              strobe_s;
  logic [MODE_W-1:0] target_s;

  // Decode this cycle's request; steps are relative to the newest known target.
  always_comb begin
    base_s      = pend_valid_r ? pend_mode_r : cfg_mode;
    req_valid_s = 1'b0;
    req_mode_s  = base_s;
    if (sel_valid) begin
      if ({1'b0, sel_mode} < MODE_LIM) begin
        req_valid_s = 1'b1;
        req_mode_s  = sel_mode;
      end else begin
        req_valid_s = 1'b0;
      end
    end else if (mode_up && !mode_down) begin
      req_valid_s = 1'b1;
      req_mode_s  = (base_s == LAST_MODE) ? {MODE_W{1'b0}} : base_s + MODE_W'(1);
    end else if (mode_down && !mode_up) begin
      req_valid_s = 1'b1;
      req_mode_s  = (base_s == {MODE_W{1'b0}}) ? LAST_MODE : base_s - MODE_W'(1);
    end else begin
      req_valid_s = 1'b0;
    end
  end

  // In RUN act on a fresh request, else on the pending one; outside RUN only latch.
  always_comb begin
    strobe_s     = 1'b0;
    target_s     = cfg_mode;
    pend_valid_s = pend_valid_r;
    pend_mode_s  = pend_mode_r;
    if (in_run) begin
      pend_valid_s = 1'b0;
      if (req_valid_s && (req_mode_s != cfg_mode)) begin
        strobe_s = 1'b1;
        target_s = req_mode_s;
      end else if (pend_valid_r && (pend_mode_r != cfg_mode)) begin
        strobe_s = 1'b1;
        target_s = pend_mode_r;
      end else begin
        strobe_s = 1'b0;
      end
    end else if (req_valid_s) begin
      pend_valid_s = 1'b1;
      pend_mode_s  = req_mode_s;
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // Pending slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_r <= 1'b0;
      pend_mode_r  <= {MODE_W{1'b0}};
    end else begin
      pend_valid_r <= pend_valid_s;
      pend_mode_r  <= pend_mode_s;
    end
  end

  assign target = target_s;
  assign strobe = strobe_s;

endmodule

// File: rtl/camera_mode_ctrl.sv
// camera_mode_ctrl: multi-mode camera bring-up sequencer.
//   clk, rst              : clock, synchronous active-high reset.
//   mode_up/mode_down     : step to next/previous mode (wrapping).
//   sel_valid/sel_mode    : direct mode select.
//   init_done             : SCCB loader finished (honoured only in INIT).
//   camera_rstn           : camera hard reset, active-low.
//   init_start            : one-cycle pulse starting the SCCB loader.
//   cfg_mode              : mode being configured or running.
//   x_lenth/y_lenth       : resolution of the running mode, valid while ready.
//   ready                 : high only in RUN.
//   init_err              : sticky init_done timeout flag.
// Build option CAMERA_MODE_CTRL_INIT_TIMEOUT_EN adds the INIT timeout; without
// it INIT waits forever and init_err is constant 0.
module camera_mode_ctrl
  import camera_pkg::*;
#(
  parameter int MODE_NUM       = 4,
  parameter int DW             = 16,
  parameter int RST_CYCLES     = 1000,
  parameter int SETTLE_CYCLES  = 20000,
  parameter int DEFAULT_MODE   = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_up,
  input  logic              mode_down,
  input  logic              sel_valid,
  input  logic [MODE_W-1:0] sel_mode,
  input  logic              init_done,
  output logic              camera_rstn,
  output logic              init_start,
  output logic [MODE_W-1:0] cfg_mode,
  output logic [DW-1:0]     x_lenth,
  output logic [DW-1:0]     y_lenth,
  output logic              ready,
  output logic              init_err
);

  // One shared interval counter; sized so the same register can also time INIT.
  localparam int CNT_MAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYCLES) ? CNT_MAX0 : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  cam_state_e        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              camera_rstn_r, camera_rstn_s;
  logic              init_start_r, init_start_s;
  logic              ready_r, ready_s;
  logic [MODE_W-1:0] cfg_mode_r, cfg_mode_s;
  logic [DW-1:0]     x_lenth_r, y_lenth_r;
  logic              load_xy_s;
  logic              init_err_r, init_err_s;
  logic [MODE_W-1:0] req_target_s;
  logic              req_strobe_s;

  cam_mode_req #(.MODE_NUM(MODE_NUM)) u_req (
    .clk       (clk),
    .rst       (rst),
    .mode_up   (mode_up),
    .mode_down (mode_down),
    .sel_valid (sel_valid),
    .sel_mode  (sel_mode),
    .cfg_mode  (cfg_mode_r),
    .in_run    (state_r == ST_RUN),
    .target    (req_target_s),
    .strobe    (req_strobe_s)
  );

  // Next-state and next-output logic; every transition into RST_ASSERT drops camera_rstn on that edge.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    camera_rstn_s = camera_rstn_r;
    init_start_s  = 1'b0;
    ready_s       = ready_r;
    cfg_mode_s    = cfg_mode_r;
    load_xy_s     = 1'b0;
    init_err_s    = init_err_r;
    case (state_r)
      ST_RST_ASSERT: begin
        camera_rstn_s = 1'b0;
        ready_s       = 1'b0;
        if (cnt_r == CNT_W'(RST_CYCLES - 1)) begin
          state_s       = ST_SETTLE;
          cnt_s         = {CNT_W{1'b0}};
          camera_rstn_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_s      = ST_INIT;
          cnt_s        = {CNT_W{1'b0}};
          init_start_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (init_done) begin
          state_s   = ST_RUN;
          cnt_s     = {CNT_W{1'b0}};
          ready_s   = 1'b1;
          load_xy_s = 1'b1;
        end else begin
`ifdef CAMERA_MODE_CTRL_INIT_TIMEOUT_EN
          if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_s       = ST_RST_ASSERT;
            cnt_s         = {CNT_W{1'b0}};
            camera_rstn_s = 1'b0;
            init_err_s    = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`else
          cnt_s = cnt_r;
`endif
        end
      end
      ST_RUN: begin
        if (req_strobe_s) begin
          state_s       = ST_RST_ASSERT;
          cnt_s         = {CNT_W{1'b0}};
          camera_rstn_s = 1'b0;
          ready_s       = 1'b0;
          cfg_mode_s    = req_target_s;
        end else begin
          ready_s = 1'b1;
        end
      end
      default: begin
        state_s       = ST_RST_ASSERT;
        cnt_s         = {CNT_W{1'b0}};
        camera_rstn_s = 1'b0;
        ready_s       = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; x/y only change on RUN entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RST_ASSERT;
      cnt_r         <= {CNT_W{1'b0}};
      camera_rstn_r <= 1'b0;
      init_start_r  <= 1'b0;
      ready_r       <= 1'b0;
      cfg_mode_r    <= MODE_W'(DEFAULT_MODE);
      x_lenth_r     <= {DW{1'b0}};
      y_lenth_r     <= {DW{1'b0}};
      init_err_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      camera_rstn_r <= camera_rstn_s;
      init_start_r  <= init_start_s;
      ready_r       <= ready_s;
      cfg_mode_r    <= cfg_mode_s;
      init_err_r    <= init_err_s;
      if (load_xy_s) begin
        x_lenth_r <= DW'(mode_width(cfg_mode_r));
        y_lenth_r <= DW'(mode_height(cfg_mode_r));
      end else begin
        x_lenth_r <= x_lenth_r;
        y_lenth_r <= y_lenth_r;
      end
    end
  end

  assign camera_rstn = camera_rstn_r;
  assign init_start  = init_start_r;
  assign ready       = ready_r;
  assign cfg_mode    = cfg_mode_r;
  assign x_lenth     = x_lenth_r;
  assign y_lenth     = y_lenth_r;
`ifdef CAMERA_MODE_CTRL_INIT_TIMEOUT_EN
  assign init_err    = init_err_r;
`else
  assign init_err    = 1'b0;
`endif

endmodule

// File: tb/tb_camera_mode_ctrl.sv
// Directed bench for camera_mode_ctrl (RST_CYCLES=4, SETTLE_CYCLES=8,
// MODE_NUM=4, init_done returned 3 cycles after init_start).
module tb_camera_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode_up = 1'b0;
  logic        mode_down = 1'b0;
  logic        sel_valid = 1'b0;
  logic [2:0]  sel_mode = 3'd0;
  logic        init_done = 1'b0;
  logic        camera_rstn;
  logic        init_start;
  logic [2:0]  cfg_mode;
  logic [15:0] x_lenth;
  logic [15:0] y_lenth;
  logic        ready;
  logic        init_err;

  logic        done_en = 1'b1;
  int          checks_cnt = 0;
  int          err_cnt = 0;

  camera_mode_ctrl #(
    .MODE_NUM(4), .DW(16), .RST_CYCLES(4), .SETTLE_CYCLES(8),
    .DEFAULT_MODE(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .mode_up(mode_up), .mode_down(mode_down),
    .sel_valid(sel_valid), .sel_mode(sel_mode), .init_done(init_done),
    .camera_rstn(camera_rstn), .init_start(init_start), .cfg_mode(cfg_mode),
    .x_lenth(x_lenth), .y_lenth(y_lenth), .ready(ready), .init_err(init_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SCCB loader model: answers init_start with a one-cycle init_done 3 clocks later.
  initial begin
    forever begin
      @(negedge clk);
      if (init_start && done_en) begin
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
      end
    end
  end

  // Drive one request cycle starting at a negedge; returns at the next negedge.
  task automatic pulse(input logic up, input logic dn, input logic sv, input logic [2:0] sm);
    mode_up = up; mode_down = dn; sel_valid = sv; sel_mode = sm;
    @(negedge clk);
    mode_up = 1'b0; mode_down = 1'b0; sel_valid = 1'b0; sel_mode = 3'd0;
  endtask

  // Called at the negedge after RST_ASSERT was entered (counter at 0).
  task automatic check_sequence(input string tag, input int prev_x, input int exp_x,
                                input int exp_y, input int exp_mode);
    check({tag, "_mode"}, cfg_mode, exp_mode);
    check({tag, "_rstn_low"}, camera_rstn, 0);
    check({tag, "_ready_low"}, ready, 0);
    check({tag, "_x_hold"}, x_lenth, prev_x);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i <= 4) check($sformatf("%s_rstn_%0d", tag, i), camera_rstn, (i == 4) ? 1 : 0);
      else if (i <= 12) check($sformatf("%s_init_start_%0d", tag, i), init_start, (i == 12) ? 1 : 0);
      else check($sformatf("%s_ready_%0d", tag, i), ready, (i == 15) ? 1 : 0);
    end
    check({tag, "_x"}, x_lenth, exp_x);
    check({tag, "_y"}, y_lenth, exp_y);
  endtask

  // Run n cycles in RUN and count any cycle where ready or camera_rstn dropped.
  task automatic check_idle(input string tag, input int n, input int exp_x, input int exp_mode);
    int drops;
    drops = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!ready || !camera_rstn) drops++;
    end
    check({tag, "_drops"}, drops, 0);
    check({tag, "_x"}, x_lenth, exp_x);
    check({tag, "_mode"}, cfg_mode, exp_mode);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rstn", camera_rstn, 0);
    check("rst_init_start", init_start, 0);
    check("rst_ready", ready, 0);
    check("rst_x", x_lenth, 0);
    check("rst_y", y_lenth, 0);
    check("rst_err", init_err, 0);
    check("rst_mode", cfg_mode, 0);
    rst = 1'b0;
    check_sequence("boot", 0, 640, 480, 0);

    // Three steps down from 0: wrap to 3, then 2, then 1.
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    check_sequence("down1", 640, 1280, 720, 3);
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    check_sequence("down2", 1280, 1024, 768, 2);
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    check_sequence("down3", 1024, 800, 600, 1);

    // Ignored requests: up+down cancel, out-of-range select, select of current mode.
    pulse(1'b1, 1'b1, 1'b0, 3'd0);
    check_idle("cancel", 10, 800, 1);
    pulse(1'b0, 1'b0, 1'b1, 3'd5);
    check_idle("sel_oor", 10, 800, 1);
    pulse(1'b0, 1'b0, 1'b1, 3'd1);
    check_idle("sel_same", 10, 800, 1);

    // Down to 0; select 2 during SETTLE and step up during INIT leave 3 pending.
    pulse(1'b0, 1'b1, 1'b0, 3'd0);
    check("pend_mode0", cfg_mode, 0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 5) begin sel_valid = 1'b1; sel_mode = 3'd2; end
      if (i == 12) mode_up = 1'b1;
      @(negedge clk);
      sel_valid = 1'b0; sel_mode = 3'd0; mode_up = 1'b0;
      if (i == 12) check("pend_init_start", init_start, 1);
    end
    check("pend_ready_pub", ready, 1);
    check("pend_x_pub", x_lenth, 640);
    check("pend_y_pub", y_lenth, 480);
    check("pend_mode_pub", cfg_mode, 0);
    @(negedge clk);
    check_sequence("pend", 640, 1280, 720, 3);

    // Step up from the last mode wraps to 0.
    pulse(1'b1, 1'b0, 1'b0, 3'd0);
    check_sequence("upwrap", 1280, 640, 480, 0);

    // Reset in the middle of a reconfiguration aborts to reset values.
    pulse(1'b1, 1'b0, 1'b0, 3'd0);
    check("abort_mode_before", cfg_mode, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rstn", camera_rstn, 0);
    check("abort_ready", ready, 0);
    check("abort_x", x_lenth, 0);
    check("abort_mode", cfg_mode, 0);
    rst = 1'b0;
    check_sequence("rerst", 0, 640, 480, 0);

`ifdef CAMERA_MODE_CTRL_INIT_TIMEOUT_EN
    // Loader never answers: timeout after 16 INIT clocks restarts with the same mode.
    done_en = 1'b0;
    pulse(1'b0, 1'b0, 1'b1, 3'd1);
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      if (i == 12) check("to_init_start", init_start, 1);
      if (i == 27) begin
        check("to_rstn_27", camera_rstn, 1);
        check("to_err_27", init_err, 0);
      end
      if (i == 28) begin
        check("to_rstn_28", camera_rstn, 0);
        check("to_err_28", init_err, 1);
        check("to_ready_28", ready, 0);
        check("to_mode_28", cfg_mode, 1);
      end
    end
    repeat (20) @(negedge clk);
    check("to_err_sticky", init_err, 1);
    rst = 1'b1;
    @(negedge clk);
    check("to_err_clr", init_err, 0);
    rst = 1'b0;
    done_en = 1'b1;
`else
    check("err_tied", init_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, err_cnt);
    $finish;
  end

endmodule
